// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the tag record carried alongside each
// K-RED operation so its result can be routed back to the issuer.
package kyber_pkg;

    localparam int KYBER_Q       = 3329;
    localparam int K2RED_CW      = 24;   // operand width
    localparam int K2RED_RW      = 12;   // result width
    localparam int K2RED_K2      = 169;  // k^2 with k = 13, q = 13*2^8 + 1
    localparam int K2RED_KLAT    = 2;    // pipeline depth of k2red
    localparam int K2RED_IDW_MAX = 3;    // wide enough for up to 8 requesters

    // One tag-pipeline stage: valid bit plus the issuing requester index.
    typedef struct packed {
        logic                     vld;
        logic [K2RED_IDW_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/k2red.sv
// K-RED reduction, two pipeline stages: cred = (K2RED_K2 * c) mod KYBER_Q.
// Uses q = 13*2^8 + 1, so 13*2^8 == -1 (mod q) and one K-RED step maps
// x = xh*2^8 + xl to 13*xl - xh == 13*x. Two steps give 169*c.
module k2red
    import kyber_pkg::*;
(
    input  logic                clk,
    input  logic                rst,   // asynchronous, active-high
    input  logic [K2RED_CW-1:0] c,
    output logic [K2RED_RW-1:0] cred
);

    // Stage 1 result: 13*c_l - c_h, range [-65535, 3315], 19-bit two's complement.
    logic [18:0]         w_t;
    logic [18:0]         r_t;
    // Stage 2 intermediates: 13*t_l - t_h, range [-12, 3571], 14-bit two's complement.
    logic [13:0]         w_t_h_ext;
    logic [13:0]         w_u;
    logic [13:0]         w_fix;
    logic [K2RED_RW-1:0] r_cred;

    // First K-RED step on the raw 24-bit operand.
    always_comb begin
        w_t = 19'd13 * {11'd0, c[7:0]} - {3'd0, c[23:8]};
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t <= '0;
        end else begin
            r_t <= w_t;
        end
    end

    // Second K-RED step with arithmetic split of the signed intermediate,
    // then a single conditional add/subtract of q lands in [0, q-1].
    always_comb begin
        w_t_h_ext = {{3{r_t[18]}}, r_t[18:8]};
        w_u       = 14'd13 * {6'd0, r_t[7:0]} - w_t_h_ext;
        if (w_u[13]) begin
            w_fix = w_u + 14'(KYBER_Q);
        end else if (w_u >= 14'(KYBER_Q)) begin
            w_fix = w_u - 14'(KYBER_Q);
        end else begin
            w_fix = w_u;
        end
    end

    // Stage 2 register drives the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cred <= '0;
        end else begin
            r_cred <= K2RED_RW'(w_fix);
        end
    end

    assign cred = r_cred;

endmodule

// File: rtl/k2red_arb.sv
// Round-robin arbiter sharing one k2red pipeline among NREQ requesters.
// A tag pipeline of 1+KLAT stages follows each operand so the result is
// returned, in accept order, with a one-hot valid to its issuer.
//
// Handshake: a transfer happens on a cycle where req_vld[i] & req_rdy[i];
// req_rdy is combinational from req_vld and the pointer and is at most
// one-hot. Requesters hold req_vld/req_c stable until accepted. Results
// have no backpressure: res_vld is a single-cycle pulse that must be taken.
module k2red_arb
    import kyber_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int KLAT = K2RED_KLAT,   // must equal the k2red depth
    localparam int IDW  = $clog2(NREQ),
    localparam int CNTW = $clog2(KLAT + 2)
)(
    input  logic                     clk,
    input  logic                     rst,       // asynchronous, active-low
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ*K2RED_CW-1:0] req_c,
    output logic [NREQ-1:0]          req_rdy,
    output logic [NREQ-1:0]          res_vld,
    output logic [K2RED_RW-1:0]      res_cred,
    output logic [CNTW-1:0]          inflight,
    output logic                     idle
);

    logic [IDW-1:0]      r_ptr;
    logic [IDW:0]        w_pick;
    logic                w_accept;
    logic [IDW-1:0]      w_gid;
    logic [IDW-1:0]      w_ptr_nxt;
    logic [K2RED_CW-1:0] w_sel_c;
    logic [K2RED_CW-1:0] r_op_q;
    tag_t                w_tag_in;
    tag_t                r_tag [KLAT+1];
    logic                w_ret;
    logic [K2RED_RW-1:0] w_cred;
    logic [CNTW-1:0]     r_inflight;
    logic                w_k2red_rst;

    // Returns {found, index} of the first valid requester scanning ptr,
    // ptr+1, ... modulo NREQ. The scan runs backwards so the smallest
    // offset from ptr is the one left in the result.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (vld[idx]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    // Grant selection, operand mux, next pointer and new tag.
    always_comb begin
        w_pick   = rr_pick(req_vld, r_ptr);
        w_accept = w_pick[IDW];
        w_gid    = w_pick[IDW-1:0];
        req_rdy  = '0;
        if (w_accept) begin
            req_rdy[w_gid] = 1'b1;
        end
        w_sel_c      = req_c[w_gid*K2RED_CW +: K2RED_CW];
        w_ptr_nxt    = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
        w_tag_in.vld = w_accept;
        w_tag_in.id  = K2RED_IDW_MAX'(w_gid);
    end

    // Round-robin pointer: moves past the granted requester, holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Input operand register feeding k2red.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_q <= '0;
        end else if (w_accept) begin
            r_op_q <= w_sel_c;
        end
    end

    // Tag pipeline shifts every cycle; stage 0 is aligned with r_op_q and
    // stage KLAT with k2red's cred. Stale pipeline data never carries a tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= KLAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i <= KLAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Result valid decoded from the last tag stage only.
    always_comb begin
        w_ret   = r_tag[KLAT].vld;
        res_vld = '0;
        for (int i = 0; i < NREQ; i++) begin
            res_vld[i] = r_tag[KLAT].vld && (r_tag[KLAT].id == K2RED_IDW_MAX'(i));
        end
    end

    // Operations accepted but not yet returned; the return cycle still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_accept, w_ret})
                2'b10:   r_inflight <= r_inflight + CNTW'(1);
                2'b01:   r_inflight <= r_inflight - CNTW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign w_k2red_rst = ~rst;

    k2red u_k2red (
        .clk  (clk),
        .rst  (w_k2red_rst),
        .c    (r_op_q),
        .cred (w_cred)
    );

    assign res_cred = w_cred;
    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0) && (req_vld == '0);

endmodule

// File: doc/k2red_arb.md
# k2red_arb

Round-robin arbiter and sequencer that shares a single `k2red` K-RED reduction pipeline (q = 3329, cred = 169·c mod 3329) among `NREQ` requesters, e.g. NTT butterfly lanes. It accepts one 24-bit operand per cycle over per-requester valid/ready handshakes and registers the selected operand. It tracks the owner of each in-flight operation through a tag pipeline matched to the `k2red` depth, then returns each 12-bit result with a one-hot valid to the requester that issued it.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `KLAT`, 2: fixed latency of the `k2red` instance, in cycles from operand to `cred`.
- `IDW`, $clog2(NREQ): requester-index width (derived; not overridden).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_vld` in NREQ: per-requester operand valid.
- `req_c` in NREQ*24: operands; requester i occupies bits [24i+23:24i].
- `req_rdy` out NREQ: one-hot grant; at most one bit high.
- `res_vld` out NREQ: one-hot result valid.
- `res_cred` out 12: reduced result, shared by all requesters.
- `inflight` out $clog2(KLAT+2): count of operations accepted but not yet returned.
- `idle` out 1: high when `inflight` = 0 and `req_vld` = 0.

## Operation
- **Arbitration.** The round-robin pointer `ptr` (IDW bits) starts the search. The grant goes to the first i with `req_vld[i]` = 1, scanning ptr, ptr+1, … modulo NREQ. `req_rdy[i]` = grant[i] is combinational from `req_vld` and `ptr`. `req_rdy` is never high for a requester whose `req_vld` is low.
- **Pointer update.** On an accept of requester g, `ptr` ← (g+1) mod NREQ. With no accept, `ptr` holds. Wrap-around from index NREQ-1 to 0 is required.
- **Handshake.** A transfer occurs on a cycle with `req_vld[i]` & `req_rdy[i]`.
  - A requester holds `req_vld` and its `req_c` stable until accepted.
  - There is no backpressure on results. A consumer must take `res_vld` in the cycle it is asserted.
- **Issue.** On accept:
  - `op_q` ← selected `req_c`.
  - Tag stage 0 ← {1, g}.
  - `op_q` drives `k2red.c`.
- **Tag pipeline.** 1+KLAT stages of {vld, id}, shifting every cycle with no stall. The final stage drives `res_vld` = vld ? onehot(id) : 0. `res_cred` = `k2red.cred`.
- **Stale data.** `res_vld` depends only on the tag pipeline. Stale `k2red` contents after reset never raise `res_vld`.
- **inflight counter.** `inflight` is +1 on accept and −1 on `res_vld`. On a simultaneous accept and return it is unchanged. Its maximum is KLAT+1.
- **Result range.** `res_cred` is in [0, 3328] for every 24-bit input.

## Timing
- Throughput is one operation per cycle, sustained, including a single requester streaming back-to-back.
- Latency: accept at edge N gives `res_vld` high during cycle N+1+KLAT (1 input-register stage plus KLAT). With the defaults, a request accepted in cycle 0 returns in cycle 3.
- Results return in accept order. Each result is reported exactly once.
- Reset values:
  - `ptr` = 0.
  - All tag valid bits = 0.
  - `op_q` = 0.
  - `inflight` = 0.
  - `res_vld` = 0.
  - `req_rdy` follows `req_vld` from `ptr` = 0.
  - `idle` = 1 once `req_vld` = 0.
  - `res_cred` = don't-care while `res_vld` = 0.
- Reset mid-operation: all in-flight operations are discarded with no `res_vld`. Requesters must reissue.
- A `req_vld` that drops without a grant is legal and leaves no state behind.

## Structure
- Shared package `kyber_pkg` holds:
  - `KYBER_Q` = 3329.
  - `K2RED_CW` = 24 (operand width).
  - `K2RED_RW` = 12 (result width).
  - `K2RED_K2` = 169.
  - A `tag_t` struct {vld, id}.
- One sub-module: `k2red` (existing), instantiated once and unmodified. Its reset pin is driven from `rst` with the polarity conversion it requires.
- The round-robin picker is a local function or generate loop, not a separate module.

## Test plan
- **Single operand.** Requester 0, c = 1 → `res_vld` = 4'b0001 three cycles after accept, `res_cred` = 169; `inflight` goes 1→0.
- **Boundary operands.** Requester 2, c = 3329, 8388608, 16777215 back-to-back → `res_cred` 0, 128, 87 on consecutive cycles; `res_vld` = 4'b0100 each time.
- **All requesters contending.** All four `req_vld` held high for 8 cycles → grants rotate 0,1,2,3,0,1,2,3. Results come back in the same order, and requester 3 with c = 99999 returns 1827.
- **Pointer rotation with a gap.** Only requesters 1 and 3 valid, `ptr` = 2 → grants 3,1,3,1. `ptr` wraps 0→2→0.
- **Reset mid-operation.** Deassert `rst` for 1 cycle with 3 operations in flight → no `res_vld` afterwards; `inflight` = 0, `ptr` = 0, `idle` = 1.
- **Random soak.** 10^6 random `req_vld`/`req_c` patterns → every accepted c returns exactly once to its issuer as (169·c) mod 3329, in order, and no two `req_rdy` bits are ever high together.
